// File: rtl/shreg_arbiter.sv
// shreg_arbiter: round-robin arbiter and write sequencer for one shared
// WIDTH-bit register written by NREQ requesters.
//
// Optional feature macro: SHREG_LOCK_EN. When defined, a requester that is
// accepted with lock[i]=1 holds the register for a burst of at most MAXBURST
// accepted beats. When undefined, lock is ignored, locked is tied low and
// arbitration is pure round-robin.
//
// Ports:
//   clk      single clock, all state updates on posedge
//   reset    synchronous, active-high
//   req      per-requester write valid
//   lock     per-requester lock request (SHREG_LOCK_EN only)
//   wdata    packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt      one-hot or zero ready, combinational from req and state
//   q        shared register contents
//   q_valid  one-cycle pulse, q was written at the preceding edge
//   owner    index of the last accepted requester
//   locked   high while in LOCKED state (this is the FSM state exposure)
//
// Handshake: a beat from requester i is accepted on a posedge where
// req[i] & gnt[i]. gnt is never asserted without the matching req bit.
// Requesters hold req/wdata until they see gnt, or drop req to withdraw.
module shreg_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAXBURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           lock,
  input  logic [NREQ*WIDTH-1:0]     wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [WIDTH-1:0]          q,
  output logic                      q_valid,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      locked
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_nxt;
  logic [NREQ-1:0] rr_gnt;
  logic [IW-1:0]   aidx;
  logic            acc;

  // Round-robin scan starting at ptr with modulo-NREQ wrap.
  always_comb begin : rr_scan
    logic [IW:0] sum;
    logic        found;
    rr_gnt = '0;
    found  = 1'b0;
    sum    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      if (!found && req[sum[IW-1:0]]) begin
        rr_gnt[sum[IW-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

  // gnt is one-hot or zero, so a plain encoder gives the accepted index.
  always_comb begin
    aidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) aidx = IW'(i);
    end
    acc     = |gnt;
    ptr_nxt = (aidx == IW'(NREQ-1)) ? '0 : aidx + IW'(1);
  end

`ifdef SHREG_LOCK_EN
  localparam int BW = $clog2(MAXBURST+1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] lowner, lowner_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;

  always_comb begin
    gnt = rr_gnt;
    if (state == LOCKED) begin
      gnt = '0;
      if (req[lowner]) gnt[lowner] = 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    lowner_nxt = lowner;
    bcnt_nxt   = bcnt;
    case (state)
      IDLE: begin
        if (acc && lock[aidx] && (MAXBURST > 1)) begin
          state_nxt  = LOCKED;
          lowner_nxt = aidx;
          bcnt_nxt   = BW'(1);
        end
      end
      LOCKED: begin
        if (acc) bcnt_nxt = bcnt + BW'(1);
        // The beat accepted on the exit edge is still written below.
        if (!lock[lowner] || (acc && (bcnt + BW'(1) == BW'(MAXBURST)))) begin
          state_nxt = IDLE;
          bcnt_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      lowner <= '0;
      bcnt   <= '0;
    end else begin
      state  <= state_nxt;
      lowner <= lowner_nxt;
      bcnt   <= bcnt_nxt;
    end
  end

  assign locked = (state == LOCKED);
`else
  logic        unused_lock;
  logic [31:0] unused_cfg;
  assign unused_lock = ^lock;
  assign unused_cfg  = MAXBURST;
  assign gnt         = rr_gnt;
  assign locked      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= '0;
      q_valid <= 1'b0;
      owner   <= '0;
      ptr     <= '0;
    end else begin
      q_valid <= acc;
      if (acc) begin
        q     <= wdata[int'(aidx)*WIDTH +: WIDTH];
        owner <= aidx;
        ptr   <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_shreg_arbiter.sv
// Testbench for shreg_arbiter: directed scenarios followed by randomized
// requesters, all compared against a behavioural model of the arbitration
// rules (priority scan, burst lock, registered write).
module tb_shreg_arbiter;
  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAXBURST = 4;
`ifdef SHREG_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic                    clk;
  logic                    reset;
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         lock;
  logic [NREQ*WIDTH-1:0]   wdata;
  logic [NREQ-1:0]         gnt;
  logic [WIDTH-1:0]        q;
  logic                    q_valid;
  logic [$clog2(NREQ)-1:0] owner;
  logic                    locked;

  shreg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .locked(locked)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // behavioural model state
  int              m_ptr, m_lowner, m_bcnt, m_owner;
  bit              m_locked, m_qv;
  logic [WIDTH-1:0] m_q;
  logic [NREQ-1:0] g_last;

  function automatic logic [NREQ-1:0] model_gnt();
    logic [NREQ-1:0] r;
    r = '0;
    if (m_locked) begin
      if (req[m_lowner]) r[m_lowner] = 1'b1;
      return r;
    end
    for (int k = 0; k < NREQ; k++) begin
      if (req[(m_ptr + k) % NREQ]) begin
        r[(m_ptr + k) % NREQ] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_edge(input logic [NREQ-1:0] g);
    int  ai;
    bit  a;
    ai = 0;
    a  = (g != 0);
    for (int i = 0; i < NREQ; i++) if (g[i]) ai = i;
    if (reset) begin
      m_ptr = 0; m_lowner = 0; m_bcnt = 0; m_owner = 0;
      m_locked = 0; m_qv = 0; m_q = '0;
      return;
    end
    m_qv = a;
    if (a) begin
      m_q     = wdata[ai*WIDTH +: WIDTH];
      m_owner = ai;
      m_ptr   = (ai + 1) % NREQ;
    end
    if (LOCK_EN) begin
      if (!m_locked) begin
        if (a && lock[ai] && MAXBURST > 1) begin
          m_locked = 1; m_lowner = ai; m_bcnt = 1;
        end
      end else begin
        if (a) m_bcnt++;
        if (!lock[m_lowner] || (a && m_bcnt == MAXBURST)) begin
          m_locked = 0; m_bcnt = 0;
        end
      end
    end
  endtask

  // One cycle: inputs already driven at negedge. Check gnt, clock, check outputs.
  task automatic step();
    logic [NREQ-1:0] eg;
    #1;
    eg = model_gnt();
    chk("gnt", gnt, eg);
    g_last = eg;
    @(posedge clk);
    model_edge(eg);
    #1;
    chk("q", q, m_q);
    chk("q_valid", q_valid, m_qv);
    chk("owner", owner, m_owner);
    chk("locked", locked, m_locked);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] lk);
    reset = r;
    req   = rq;
    lock  = lk;
  endtask

  bit              pend [NREQ];
  logic [WIDTH-1:0] pdat [NREQ];

  initial begin
    m_ptr = 0; m_lowner = 0; m_bcnt = 0; m_owner = 0;
    m_locked = 0; m_qv = 0; m_q = '0; g_last = '0;
    reset = 1'b1; req = '0; lock = '0; wdata = '0;
    for (int i = 0; i < NREQ; i++) wdata[i*WIDTH +: WIDTH] = WIDTH'(8'h10 + i);
    @(negedge clk);
    step();
    step();

    // reset state, idle
    drive(1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_q", q, 0);
      chk("idle_qv", q_valid, 0);
      chk("idle_gnt", gnt, 0);
    end

    // all requesting: order 0,1,2,3,0
    drive(1'b0, 4'b1111, '0);
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_gnt", gnt, 32'(1) << (k % 4));
      step();
      chk("rr_q", q, 8'h10 + (k % 4));
      chk("rr_qv", q_valid, 1);
    end

    // ptr=3 after accept from 2, then wrap
    drive(1'b0, 4'b0100, '0);
    step();
    drive(1'b0, 4'b1001, '0);
    #1 chk("wrap_g3", gnt, 4'b1000);
    step();
    #1 chk("wrap_g0", gnt, 4'b0001);
    step();

    if (LOCK_EN) begin
      // ptr -> 1, then requester 1 bursts
      drive(1'b0, 4'b0001, '0);
      step();
      drive(1'b0, 4'b1111, 4'b0010);
      for (int k = 0; k < 4; k++) begin
        #1 chk("burst_g1", gnt, 4'b0010);
        step();
        if (k < 3) chk("burst_locked", locked, 1);
      end
      chk("burst_exit", locked, 0);
      #1 chk("burst_next", gnt, 4'b0100);
      step();
      // ptr -> 0, requester 0 locks, reset after 2 beats
      drive(1'b0, 4'b1000, '0);
      step();
      drive(1'b0, 4'b0001, 4'b0001);
      step();
      step();
      chk("lk_locked", locked, 1);
      drive(1'b1, 4'b0001, 4'b0001);
      step();
      chk("rst_q", q, 0);
      chk("rst_locked", locked, 0);
      drive(1'b0, 4'b0001, 4'b0001);
      #1 chk("rst_g0", gnt, 4'b0001);
      step();
      chk("rst_owner", owner, 0);
    end else begin
      // lock ignored: alternate 0,1
      drive(1'b0, 4'b1000, 4'b1111);
      step();
      drive(1'b0, 4'b0011, 4'b1111);
      for (int k = 0; k < 4; k++) begin
        #1 chk("nolock_g", gnt, 32'(1) << (k % 2));
        step();
        chk("nolock_locked", locked, 0);
      end
    end

    // randomized requesters
    for (int i = 0; i < NREQ; i++) begin pend[i] = 0; pdat[i] = '0; end
    g_last = '0;
    lock = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && g_last[i]) pend[i] = 0;
        if (pend[i] && $urandom_range(0, 9) == 0) pend[i] = 0;
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          pdat[i] = WIDTH'($urandom);
        end
        req[i] = pend[i];
        wdata[i*WIDTH +: WIDTH] = pdat[i];
        if ($urandom_range(0, 5) == 0) lock[i] = ~lock[i];
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
